// File: rtl/iq_pkg.sv
// Shared types, default widths and the signed saturate-add helper for the I/Q accumulator.
package iq_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INTEGRATE = 2'd1,
    HOLD      = 2'd2
  } iq_state_e;

  localparam int DEF_LANES  = 5;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ACC_W  = 32;
  localparam int DEF_LEN_W  = 11;

  // Adds two sign-extended operands and clips the result to a w-bit signed range (w <= 63).
  function automatic logic signed [63:0] sat_add(
    input  logic signed [63:0] a,
    input  logic signed [63:0] b,
    input  int                 w,
    output logic               clip
  );
    logic signed [64:0] s;
    logic signed [64:0] hi;
    logic signed [64:0] lo;
    s    = {a[63], a} + {b[63], b};
    hi   = (65'sd1 <<< (w - 1)) - 65'sd1;
    lo   = -(65'sd1 <<< (w - 1));
    clip = 1'b0;
    if (s > hi) begin
      clip    = 1'b1;
      sat_add = hi[63:0];
    end else if (s < lo) begin
      clip    = 1'b1;
      sat_add = lo[63:0];
    end else begin
      sat_add = s[63:0];
    end
  endfunction

endpackage

// File: rtl/lane_adder_tree.sv
// Combinational masked sum of LANES packed signed samples, each sign-extended to ACC_W.
// Zero latency; no handshake of its own.
module lane_adder_tree
  import iq_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic [LANES-1:0]        lane_valid,
  input  logic [LANES*DATA_W-1:0] data,
  output logic signed [ACC_W-1:0] sum
);

  logic signed [DATA_W-1:0] lane;

  always_comb begin
    sum  = '0;
    lane = '0;
    for (int k = 0; k < LANES; k++) begin
      lane = data[k*DATA_W +: DATA_W];
      if (lane_valid[k]) begin
        sum = sum + ACC_W'(lane);
      end
    end
  end

endmodule

// File: rtl/iq_accumulator.sv
// Integrates LANES I/Q samples over sample_length beats; result valid the cycle after the last beat
// and held until iq_ready. Starts while busy are dropped. IQ_SAT_EN enables saturating accumulation.
module iq_accumulator
  import iq_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic                     clk100,
  input  logic                     reset,
  input  logic                     start,
  input  logic [LEN_W-1:0]         sample_length,
  input  logic [LANES-1:0]         lane_valid,
  input  logic [LANES*DATA_W-1:0]  data_i_rot,
  input  logic [LANES*DATA_W-1:0]  data_q_rot,
  output logic signed [ACC_W-1:0]  i_val,
  output logic signed [ACC_W-1:0]  q_val,
  output logic                     iq_valid,
  input  logic                     iq_ready,
  output logic                     busy,
  output logic                     start_dropped,
  output logic                     sat_flag
);

`ifdef IQ_SAT_EN
  // Lane sum kept wide enough that saturation sees the true beat total.
  localparam int SUM_W = ACC_W + $clog2(LANES) + 1;
`else
  localparam int SUM_W = ACC_W;
`endif

  logic signed [SUM_W-1:0] sum_i;
  logic signed [SUM_W-1:0] sum_q;

  lane_adder_tree #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .ACC_W  (SUM_W)
  ) u_tree_i (
    .lane_valid (lane_valid),
    .data       (data_i_rot),
    .sum        (sum_i)
  );

  lane_adder_tree #(
    .LANES  (LANES),
    .DATA_W (DATA_W),
    .ACC_W  (SUM_W)
  ) u_tree_q (
    .lane_valid (lane_valid),
    .data       (data_q_rot),
    .sum        (sum_q)
  );

  iq_state_e               state, state_nxt;
  logic [LEN_W-1:0]        len_q, len_nxt;
  logic [LEN_W-1:0]        cnt_q, cnt_nxt;
  logic signed [ACC_W-1:0] acc_i, acc_i_nxt;
  logic signed [ACC_W-1:0] acc_q, acc_q_nxt;
  logic signed [ACC_W-1:0] base_i, base_q;
  logic signed [ACC_W-1:0] add_i, add_q;
  logic                    dropped_q, dropped_nxt;
  logic                    clip_any;

`ifdef IQ_SAT_EN
  logic sat_q, sat_nxt;
  logic clip_i, clip_q;
`endif

  // The first beat of a window loads rather than accumulates, so IDLE contributes a zero base.
  always_comb begin
    base_i = (state == IDLE) ? '0 : acc_i;
    base_q = (state == IDLE) ? '0 : acc_q;
`ifdef IQ_SAT_EN
    clip_i   = 1'b0;
    clip_q   = 1'b0;
    add_i    = ACC_W'(sat_add(64'(base_i), 64'(sum_i), ACC_W, clip_i));
    add_q    = ACC_W'(sat_add(64'(base_q), 64'(sum_q), ACC_W, clip_q));
    clip_any = clip_i | clip_q;
`else
    add_i    = base_i + sum_i;
    add_q    = base_q + sum_q;
    clip_any = 1'b0;
`endif
  end

  always_comb begin
    state_nxt   = state;
    len_nxt     = len_q;
    cnt_nxt     = cnt_q;
    acc_i_nxt   = acc_i;
    acc_q_nxt   = acc_q;
    dropped_nxt = 1'b0;
`ifdef IQ_SAT_EN
    sat_nxt     = sat_q;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          if (sample_length != '0) begin
            len_nxt   = sample_length;
            acc_i_nxt = add_i;
            acc_q_nxt = add_q;
            cnt_nxt   = LEN_W'(1);
`ifdef IQ_SAT_EN
            sat_nxt   = clip_any;
`endif
            state_nxt = (sample_length == LEN_W'(1)) ? HOLD : INTEGRATE;
          end else begin
            dropped_nxt = 1'b1;
          end
        end
      end
      INTEGRATE: begin
        dropped_nxt = start;
        acc_i_nxt   = add_i;
        acc_q_nxt   = add_q;
        cnt_nxt     = cnt_q + LEN_W'(1);
`ifdef IQ_SAT_EN
        sat_nxt     = sat_q | clip_any;
`endif
        if (cnt_nxt == len_q) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        dropped_nxt = start;
        if (iq_ready) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      len_q     <= '0;
      cnt_q     <= '0;
      acc_i     <= '0;
      acc_q     <= '0;
      dropped_q <= 1'b0;
    end else begin
      len_q     <= len_nxt;
      cnt_q     <= cnt_nxt;
      acc_i     <= acc_i_nxt;
      acc_q     <= acc_q_nxt;
      dropped_q <= dropped_nxt;
    end
  end

`ifdef IQ_SAT_EN
  always_ff @(posedge clk100 or posedge reset) begin
    if (reset) begin
      sat_q <= 1'b0;
    end else begin
      sat_q <= sat_nxt;
    end
  end
  assign sat_flag = sat_q;
`else
  assign sat_flag = clip_any;
`endif

  assign i_val         = acc_i;
  assign q_val         = acc_q;
  assign iq_valid      = (state == HOLD);
  assign busy          = (state != IDLE);
  assign start_dropped = dropped_q;

endmodule

// File: doc/iq_accumulator.md
Name: iq_accumulator

Overview:
- Parametrised successor to the readout integrator.
- Accumulates LANES rotated I/Q samples per clock over a programmable window of sample_length beats.
- A per-lane valid mask replaces the "phase == 0" skip test.
- Presents the I/Q sums on a valid/ready handshake to the downstream binning/classifier stage.
- Sits between the multiplier (rotation) stage and the analysis stage.

Parameters:
- LANES, 5, samples presented per clock.
- DATA_W, 16, signed width of each rotated I/Q sample.
- ACC_W, 32, signed accumulator/output width.
- LEN_W, 11, width of sample_length (beats per window).

Ports:
- clk100  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-high reset
- start  in  1  pulse; first beat of window is the same cycle
- sample_length  in  LEN_W  window length in beats; sampled at accepted start
- lane_valid  in  LANES  per-lane sample qualifier
- data_i_rot  in  LANES*DATA_W  packed signed I samples; lane k at [k*DATA_W +: DATA_W]
- data_q_rot  in  LANES*DATA_W  packed signed Q samples; same packing
- i_val  out  ACC_W  signed I sum
- q_val  out  ACC_W  signed Q sum
- iq_valid  out  1  result available
- iq_ready  in  1  downstream accepts result
- busy  out  1  high in INTEGRATE or HOLD
- start_dropped  out  1  one-cycle pulse: start ignored
- sat_flag  out  1  sticky per window: accumulator clipped (IQ_SAT_EN only; else tied 0)

Behaviour:
- Reset (async assert, sync release): state IDLE; i_val=q_val=0; iq_valid=0; busy=0; start_dropped=0; sat_flag=0; beat counter=0. Reset mid-window aborts the window with no output.
- States: IDLE, INTEGRATE, HOLD.
- Lane sum each cycle: sign-extend each lane to ACC_W, zero it if lane_valid[k]=0, then add all lanes combinationally. Overflow wraps (two's complement) unless IQ_SAT_EN is defined.
- IDLE, start=1, sample_length!=0:
  - Latch sample_length.
  - Accumulators load this cycle's lane sum (not added to the stale value).
  - counter=1.
  - Go to HOLD if sample_length==1, else INTEGRATE.
- IDLE, start=1, sample_length==0: ignored; start_dropped pulses.
- INTEGRATE, each cycle:
  - acc += lane sum; counter++.
  - When the beat being added is beat number sample_length, go to HOLD.
  - Total beats accumulated = sample_length exactly.
- HOLD:
  - iq_valid=1; i_val/q_val are stable.
  - On iq_valid && iq_ready, go to IDLE next cycle and drop iq_valid.
  - iq_ready while not valid has no effect.
- Latency: iq_valid rises the cycle after the last beat is sampled.
- A start in INTEGRATE or HOLD (including the HOLD handshake cycle) is ignored and start_dropped pulses. There is no back-to-back acceptance.
- i_val/q_val show the running accumulator during INTEGRATE. They are only meaningful when iq_valid=1.
- busy=1 in INTEGRATE and HOLD.

Optional Feature:
- Macro IQ_SAT_EN.
- Defined:
  - Each accumulate saturates to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - sat_flag is set on any clip, cleared at an accepted start, and held through HOLD.
- Undefined:
  - Plain wrap-around addition.
  - sat_flag is constant 0 and no saturation logic is generated.

Decomposition:
- Shared package iq_pkg holds:
  - state enum (IDLE/INTEGRATE/HOLD);
  - default width constants DATA_W=16, ACC_W=32, LEN_W=11;
  - a function for signed saturate-add.
- One natural sub-module: lane_adder_tree. It performs the masked sign-extended sum of LANES samples and is combinational, parametrised by LANES/DATA_W/ACC_W.

Test Plan:
- Basic window:
  - Stimulus: sample_length=4; all lanes valid; every lane I=1, Q=-2; iq_ready=1.
  - Required: iq_valid one cycle after the 4th beat; i_val=20, q_val=-40; IDLE the next cycle.
- Masking:
  - Stimulus: sample_length=3; lane_valid=5'b00101; I lanes=100.
  - Required: i_val=600.
- Hold/backpressure:
  - Stimulus: iq_ready=0 for 10 cycles after valid, plus a start pulse during HOLD.
  - Required: i_val/q_val stable; start_dropped pulses once; handshake completes when iq_ready=1.
- Edge lengths:
  - Stimulus: sample_length=1, then sample_length=0.
  - Required: length 1 gives valid on the next cycle with the single-beat sum; length 0 is ignored with start_dropped=1 and busy=0.
- Async reset:
  - Stimulus: reset asserted mid-INTEGRATE between clock edges.
  - Required: all outputs 0 immediately; no iq_valid afterwards; a new start works normally.
- IQ_SAT_EN:
  - Stimulus: I lanes=32767 on all 5 lanes, ACC_W=18, sample_length=4.
  - Required: i_val=131071 and sat_flag=1 with the macro; wrapped value and sat_flag=0 without.
